// File: rtl/cache_arbiter_pkg.sv
// Shared types and default widths for the I/D cache-to-memory arbiter.
package cache_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_e;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one memory port.
// One transaction at a time; contention alternates against the last served side.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LINE_W = LINE_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp
);

  state_e              r_state;
  side_e               r_last_grant;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic                r_m_read;
  logic                r_m_write;
  logic [LINE_W-1:0]   r_i_rdata;
  logic [LINE_W-1:0]   r_d_rdata;
  logic                r_i_resp;
  logic                r_d_resp;

  state_e              w_state_nxt;
  side_e               w_grant_side;
  logic                w_grant;
  logic                w_done;
  logic                w_d_req;

  assign w_d_req = d_read | d_write;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, grant selection and memory-completion decode
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_side = SIDE_I;
    w_grant      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_read && w_d_req) begin
          w_grant_side = (r_last_grant == SIDE_I) ? SIDE_D : SIDE_I;
        end else if (w_d_req) begin
          w_grant_side = SIDE_D;
        end
        if (i_read || w_d_req) begin
          w_grant     = 1'b1;
          w_state_nxt = (w_grant_side == SIDE_D) ? ST_BUSY_D : ST_BUSY_I;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (m_resp) begin
          w_done      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Request capture, memory command, returned-line and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= SIDE_D;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_m_read     <= 1'b0;
      r_m_write    <= 1'b0;
      r_i_rdata    <= '0;
      r_d_rdata    <= '0;
      r_i_resp     <= 1'b0;
      r_d_resp     <= 1'b0;
    end else begin
      r_i_resp <= w_done && (r_state == ST_BUSY_I);
      r_d_resp <= w_done && (r_state == ST_BUSY_D);
      if (w_grant) begin
        if (w_grant_side == SIDE_D) begin
          // Writeback wins when both D-side ops are raised together
          r_addr    <= d_address;
          r_wdata   <= d_wdata;
          r_m_write <= d_write;
          r_m_read  <= ~d_write;
        end else begin
          r_addr    <= i_address;
          r_wdata   <= '0;
          r_m_write <= 1'b0;
          r_m_read  <= 1'b1;
        end
      end
      if (w_done) begin
        r_m_read  <= 1'b0;
        r_m_write <= 1'b0;
        if (r_state == ST_BUSY_D) begin
          r_last_grant <= SIDE_D;
          if (r_m_read) begin
            r_d_rdata <= m_rdata;
          end
        end else begin
          r_last_grant <= SIDE_I;
          r_i_rdata    <= m_rdata;
        end
      end
    end
  end

  assign m_read    = r_m_read;
  assign m_write   = r_m_write;
  assign m_address = r_addr;
  assign m_wdata   = r_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_resp    = r_i_resp;
  assign d_resp    = r_d_resp;

endmodule
